counter_4bit_load: RTL and testbench

- Synchronous up-counter, WIDTH bits (4 by default), with a parallel-load input.
- Supports count enable, hold, and wrap-around, plus a terminal-count flag for cascading.
- General-purpose building block for sequencers and timers in the datapath; one clock domain.

---
 rtl/counter_4bit_load_pkg.sv | 15 +
 rtl/counter_4bit_load.sv | 41 ++++
 tb/tb_counter_4bit_load.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/counter_4bit_load_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_4bit_load_pkg
// Description : Shared constants for the loadable up-counter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_4bit_load_pkg;

    localparam int c_default_width = 4;

    // Every bit of the counter clears to this value on reset.
    localparam logic c_counter_rst_bit = 1'b0;

endpackage
`default_nettype wire

// File: rtl/counter_4bit_load.sv
`default_nettype none
// ============================================================================
// Module      : counter_4bit_load
// Description : WIDTH-bit synchronous up-counter with parallel load, count
//               enable, wrap-around and a combinational terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_4bit_load
    import counter_4bit_load_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    logic [WIDTH-1:0] r_q;
    logic             w_all_ones;

    // Load takes priority over count; d is never observed unless load is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= {WIDTH{c_counter_rst_bit}};
        end else if (load) begin
            r_q <= d;
        end else if (en) begin
            r_q <= r_q + WIDTH'(1);
        end
    end

    assign w_all_ones = &r_q;
    assign q          = r_q;
    assign tc         = w_all_ones & en & ~load & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_counter_4bit_load.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_4bit_load
// Description : Directed and randomized self-checking bench for the counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_4bit_load;

    localparam int W    = 4;
    localparam int MODV = 1 << W;
    localparam int MAXV = MODV - 1;

    logic         clk;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] d;
    logic [W-1:0] q;
    logic         tc;

    int n_vec;
    int n_err;
    int m_q;

    counter_4bit_load #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .load (load),
        .d    (d),
        .q    (q),
        .tc   (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic exp_tc(input logic e, input logic l, input logic r);
        return (m_q == MAXV) && e && !l && !r;
    endfunction

    // Drive one cycle of inputs at the falling edge, check before and after the rising edge.
    task automatic step(input logic e, input logic l, input logic [W-1:0] dv, input logic r);
        en   = e;
        load = l;
        d    = dv;
        rst  = r;
        #1;
        if (r) m_q = 0;
        chk("q_pre", 32'(q), 32'(m_q));
        chk("tc_pre", 32'(tc), 32'(exp_tc(e, l, r)));
        @(posedge clk);
        if (r)      m_q = 0;
        else if (l) m_q = int'(dv);
        else if (e) m_q = (m_q + 1) % MODV;
        #1;
        chk("q_post", 32'(q), 32'(m_q));
        chk("tc_post", 32'(tc), 32'(exp_tc(e, l, r)));
        @(negedge clk);
    endtask

    // Reset raised between edges must clear q without waiting for a clock.
    task automatic mid_reset();
        en   = 1'b1;
        load = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        m_q = 0;
        chk("async_rst_q", 32'(q), 32'd0);
        chk("async_rst_tc", 32'(tc), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold_q", 32'(q), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_q   = 0;
        rst   = 1'b1;
        en    = 1'b0;
        load  = 1'b0;
        d     = '0;

        step(1'b0, 1'b0, 4'd0, 1'b1);
        chk("lit_reset", 32'(q), 32'd0);

        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_count2", 32'(q), 32'd2);

        step(1'b0, 1'b1, 4'd5, 1'b0);
        chk("lit_load5", 32'(q), 32'd5);
        step(1'b1, 1'b1, 4'd5, 1'b0);
        chk("lit_load_beats_en", 32'(q), 32'd5);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_resume9", 32'(q), 32'd9);
        step(1'b0, 1'b0, 4'd3, 1'b0);
        chk("lit_hold9", 32'(q), 32'd9);

        step(1'b0, 1'b1, 4'd12, 1'b0);
        chk("lit_load12", 32'(q), 32'd12);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_q14", 32'(q), 32'd14);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_q15", 32'(q), 32'd15);
        chk("lit_tc_at15", 32'(tc), 32'd1);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_wrap0", 32'(q), 32'd0);
        chk("lit_tc_after_wrap", 32'(tc), 32'd0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_q1", 32'(q), 32'd1);

        // Hold with load low: d toggles, including unknown values.
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b0, W'($urandom), 1'b0);
            else            step(1'b0, 1'b0, 'x, 1'b0);
        end
        chk("lit_hold_d_toggle", 32'(q), 32'd1);

        // Load all ones with en low: tc must stay low until en rises.
        step(1'b0, 1'b1, 4'd15, 1'b0);
        chk("lit_tc_en_low", 32'(tc), 32'd0);
        step(1'b1, 1'b1, 4'd15, 1'b0);
        chk("lit_tc_load_high", 32'(tc), 32'd0);

        step(1'b1, 1'b0, 4'd0, 1'b0);
        step(1'b1, 1'b0, 4'd0, 1'b0);
        mid_reset();
        step(1'b1, 1'b0, 4'd0, 1'b0);
        chk("lit_after_midrst", 32'(q), 32'd1);

        for (int i = 0; i < 2000; i++) begin
            int sel;
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                mid_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 7) == 0,
                     W'($urandom),
                     sel < 4);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
